// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared HI/LO op encodings, FSM states and default latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic f_is_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic f_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage : mdu_ctrl_pkg
`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl_if
// Description : EX/ID side bundle of the HI/LO sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_ctrl_if;

  logic [2:0]  md_op_ex;
  logic [31:0] rs_ex;
  logic [31:0] rt_ex;
  logic        cancel_ex;
  logic        md_use_id;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;

  modport master (
    output md_op_ex, rs_ex, rt_ex, cancel_ex, md_use_id,
    input  hi, lo, busy, stall_md
  );

  modport slave (
    input  md_op_ex, rs_ex, rt_ex, cancel_ex, md_use_id,
    output hi, lo, busy, stall_md
  );

endinterface : mdu_ctrl_if
`default_nettype wire

// File: rtl/mdu_ctrl_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational 64-bit {hi,lo} generator for mult/div ops.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  wire logic [2:0]  i_op,
  input  wire logic [31:0] i_rs,
  input  wire logic [31:0] i_rt,
  output md_res_t          o_res
);

  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic               w_div0;
  logic               w_ovf;
  logic        [31:0] w_sdsr;
  logic        [31:0] w_udsr;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquo;
  logic        [31:0] w_urem;

  assign w_smul = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_umul = {32'd0, i_rs} * {32'd0, i_rt};

  // Divisors are forced to 1 on the special cases so the dividers never see /0 or overflow.
  assign w_div0 = (i_rt == 32'd0);
  assign w_ovf  = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);
  assign w_sdsr = (w_div0 || w_ovf) ? 32'd1 : i_rt;
  assign w_udsr = w_div0 ? 32'd1 : i_rt;

  assign w_squo = $signed(i_rs) / $signed(w_sdsr);
  assign w_srem = $signed(i_rs) % $signed(w_sdsr);
  assign w_uquo = i_rs / w_udsr;
  assign w_urem = i_rs % w_udsr;

  always_comb begin
    o_res = '0;
    case (i_op)
      MD_MULT:  o_res = w_smul;
      MD_MULTU: o_res = w_umul;
      MD_DIV: begin
        if (w_div0) begin
          o_res.hi = i_rs;
          o_res.lo = 32'hFFFF_FFFF;
        end else if (w_ovf) begin
          o_res.hi = 32'd0;
          o_res.lo = 32'h8000_0000;
        end else begin
          o_res.hi = w_srem;
          o_res.lo = w_squo;
        end
      end
      MD_DIVU: begin
        if (w_div0) begin
          o_res.hi = i_rs;
          o_res.lo = 32'hFFFF_FFFF;
        end else begin
          o_res.hi = w_urem;
          o_res.lo = w_uquo;
        end
      end
      default: o_res = '0;
    endcase
  end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : HI/LO multiply/divide sequencer with busy counter and ID stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  mdu_ctrl_if.slave  bus
);

  localparam logic [3:0] c_MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] c_DIV_LAT  = 4'(DIV_CYCLES);

  logic [0:0]  r_state;
  logic [3:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_shadow_hi;
  logic [31:0] r_shadow_lo;

  md_res_t     w_res;
  logic        w_idle;
  logic        w_start;
  logic        w_mthi;
  logic        w_mtlo;

  mdu_arith u_arith (
    .i_op  (bus.md_op_ex),
    .i_rs  (bus.rs_ex),
    .i_rt  (bus.rt_ex),
    .o_res (w_res)
  );

  // Ops arriving while BUSY are dropped: only IDLE may start or write.
  assign w_idle  = (r_state == S_IDLE);
  assign w_start = w_idle && f_is_start(bus.md_op_ex) && !bus.cancel_ex;
  assign w_mthi  = w_idle && (bus.md_op_ex == MD_MTHI) && !bus.cancel_ex;
  assign w_mtlo  = w_idle && (bus.md_op_ex == MD_MTLO) && !bus.cancel_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= 4'd0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_shadow_hi <= 32'd0;
      r_shadow_lo <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shadow_hi <= w_res.hi;
            r_shadow_lo <= w_res.lo;
            r_count     <= f_is_div(bus.md_op_ex) ? c_DIV_LAT : c_MULT_LAT;
            r_state     <= S_BUSY;
          end
          if (w_mthi) r_hi <= bus.rs_ex;
          if (w_mtlo) r_lo <= bus.rs_ex;
        end
        S_BUSY: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_hi    <= r_shadow_hi;
            r_lo    <= r_shadow_lo;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = (r_state == S_BUSY) || w_start;
  assign bus.stall_md = bus.md_use_id && bus.busy;

endmodule : mdu_ctrl
`default_nettype wire
